conv_encoder_punct: RTL and testbench

Serial K=7 convolutional encoder with 802.11a puncturing, directly downstream of the Transmitter scrambler stage; consumes one scrambled bit per accepted handshake. Implements generators g0=133o (A) and g1=171o (B), punctures to rate 1/2, 2/3 or 3/4 and emits coded bits serially, one per cycle, with valid/ready flow control on both sides. Feeds the interleaver stage.

---
 rtl/conv_encoder_punct_pkg.sv | 40 ++++
 rtl/conv_encoder_punct_core.sv | 47 ++++
 rtl/conv_encoder_punct.sv | 109 ++++++++++
 tb/tb_conv_encoder_punct.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_encoder_punct_pkg.sv
// Shared constants and types for the K=7 punctured convolutional encoder.
// Generator constants are written MSB = current input bit, LSB = oldest delay.
package conv_encoder_punct_pkg;

  localparam int K   = 7;
  localparam int MEM = K - 1;

  localparam logic [K-1:0] G0 = 7'o133;
  localparam logic [K-1:0] G1 = 7'o171;

  typedef enum logic [1:0] {
    RATE_1_2  = 2'd0,
    RATE_2_3  = 2'd1,
    RATE_3_4  = 2'd2,
    RATE_RSVD = 2'd3
  } rate_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Reserved code behaves as rate 1/2.
  function automatic rate_e norm_rate(input logic [1:0] r);
    case (r)
      2'd1:    return RATE_2_3;
      2'd2:    return RATE_3_4;
      default: return RATE_1_2;
    endcase
  endfunction

  function automatic logic [1:0] phase_last(input rate_e r);
    case (r)
      RATE_2_3: return 2'd1;
      RATE_3_4: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/conv_encoder_punct_core.sv
// K=7 shift register with the A/B generator taps; shifts only on adv_i.
// sreg_q[MEM-1] holds the most recent past bit, sreg_q[0] the oldest.
module conv_encoder_punct_core
  import conv_encoder_punct_pkg::*;
(
  input  logic clk_i,
  input  logic srst_i,
  input  logic clr_i,
  input  logic adv_i,
  input  logic bit_i,
  output logic a_o,
  output logic b_o
);

  logic [MEM-1:0] sreg_q, sreg_d;
  logic [K-1:0]   window;
  logic [K-1:0]   a_terms;
  logic [K-1:0]   b_terms;

  assign window = {bit_i, sreg_q};

  for (genvar gi = 0; gi < K; gi++) begin : g_taps
    assign a_terms[gi] = window[gi] & G0[gi];
    assign b_terms[gi] = window[gi] & G1[gi];
  end

  assign a_o = ^a_terms;
  assign b_o = ^b_terms;

  always_comb begin
    sreg_d = sreg_q;
    if (clr_i) begin
      sreg_d = '0;
    end else if (adv_i) begin
      sreg_d = {bit_i, sreg_q[MEM-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

endmodule

// File: rtl/conv_encoder_punct.sv
// Serial K=7 convolutional encoder with 802.11a puncturing (1/2, 2/3, 3/4)
// and a 2-entry output buffer with valid/ready on both sides.
module conv_encoder_punct
  import conv_encoder_punct_pkg::*;
(
  input  logic       clk_i,
  input  logic       srst_i,
  input  logic       start_i,
  input  logic [1:0] rate_i,
  input  logic       in_bit_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic       out_bit_o,
  output logic       out_valid_o,
  input  logic       out_ready_i
);

  state_e     state_q, state_d;
  rate_e      rate_q, rate_d;
  logic [1:0] phase_q, phase_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] buf_q, buf_d;
  logic [1:0] kept_cnt, kept_buf;
  logic       pop, accept;
  logic       core_a, core_b;
  logic       emit_a, emit_b, emit_bit;

  conv_encoder_punct_core u_core (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .clr_i  (start_i),
    .adv_i  (accept),
    .bit_i  (in_bit_i),
    .a_o    (core_a),
    .b_o    (core_b)
  );

  assign out_valid_o = !srst_i && (cnt_q != 2'd0);
  assign out_bit_o   = out_valid_o & buf_q[0];
  assign pop         = out_valid_o & out_ready_i;
  assign in_ready_o  = (state_q == ST_RUN) && !start_i && !srst_i &&
                       ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && out_ready_i));
  assign accept      = in_valid_i & in_ready_o;

  always_comb begin
    emit_a = 1'b1;
    emit_b = 1'b1;
    case (rate_q)
      RATE_2_3: emit_b = (phase_q == 2'd0);
      RATE_3_4: begin
        emit_a = (phase_q != 2'd2);
        emit_b = (phase_q != 2'd1);
      end
      default: ;
    endcase
  end

  // An accept only happens when the buffer is empty after this cycle's pop,
  // so a two-bit emission always lands in a clean buffer.
  always_comb begin
    kept_buf = pop ? {1'b0, buf_q[1]} : buf_q;
    kept_cnt = cnt_q - {1'b0, pop};
    buf_d    = kept_buf;
    cnt_d    = kept_cnt;
    emit_bit = emit_a ? core_a : core_b;
    if (start_i) begin
      buf_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      if (emit_a && emit_b) begin
        buf_d = {core_b, core_a};
        cnt_d = 2'd2;
      end else begin
        buf_d[kept_cnt[0]] = emit_bit;
        cnt_d              = kept_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rate_d  = rate_q;
    phase_d = phase_q;
    if (start_i) begin
      state_d = ST_RUN;
      rate_d  = norm_rate(rate_i);
      phase_d = '0;
    end else if (accept) begin
      phase_d = (phase_q == phase_last(rate_q)) ? 2'd0 : phase_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= ST_IDLE;
      rate_q  <= RATE_1_2;
      phase_q <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      rate_q  <= rate_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_conv_encoder_punct.sv
// Self-checking bench: queue-based reference model of the punctured encoder,
// compared against the DUT every cycle, plus literal impulse responses.
module tb_conv_encoder_punct;

  logic       clk = 1'b0;
  logic       srst, start, in_bit, in_valid, out_ready;
  logic [1:0] rate;
  logic       in_ready, out_bit, out_valid;

  always #5 clk = ~clk;

  conv_encoder_punct dut (
    .clk_i       (clk),
    .srst_i      (srst),
    .start_i     (start),
    .rate_i      (rate),
    .in_bit_i    (in_bit),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_bit_o   (out_bit),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  bit m_run   = 1'b0;
  int m_rate  = 0;
  int m_phase = 0;
  bit past[$];
  bit exp_q[$];
  bit got[$];
  int acc_cycle[$];
  bit prev_hold = 1'b0;
  bit prev_bit  = 1'b0;
  bit rand_ready = 1'b0;

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit dly(int k);
    return (past.size() >= k) ? past[k-1] : 1'b0;
  endfunction

  // Reference: A = b^d2^d3^d5^d6, B = b^d1^d2^d3^d6, then puncture by phase.
  function automatic void model_accept(bit b);
    bit a, bb;
    int period;
    a  = b ^ dly(2) ^ dly(3) ^ dly(5) ^ dly(6);
    bb = b ^ dly(1) ^ dly(2) ^ dly(3) ^ dly(6);
    period = (m_rate == 2) ? 3 : (m_rate == 1) ? 2 : 1;
    if (m_phase == 0) begin
      exp_q.push_back(a);
      exp_q.push_back(bb);
    end else if (m_phase == 1) begin
      exp_q.push_back(a);
    end else begin
      exp_q.push_back(bb);
    end
    past.push_front(b);
    if (past.size() > 6) void'(past.pop_back());
    m_phase = (m_phase + 1) % period;
  endfunction

  always @(negedge clk) begin
    bit exp_rdy, exp_vld;
    cyc++;
    exp_vld = !srst && (exp_q.size() != 0);
    exp_rdy = !srst && !start && m_run &&
              ((exp_q.size() == 0) || ((exp_q.size() == 1) && out_ready));
    check("out_valid", int'(out_valid), int'(exp_vld));
    check("in_ready", int'(in_ready), int'(exp_rdy));
    check("out_bit", int'(out_bit), exp_vld ? int'(exp_q[0]) : 0);
    if (prev_hold && !srst) check("hold_stable", int'(out_bit), int'(prev_bit));
    prev_hold = out_valid && !out_ready && !srst && !start;
    prev_bit  = out_bit;
    if (out_valid && out_ready && !srst) got.push_back(out_bit);
    if (in_valid && in_ready) acc_cycle.push_back(cyc);
    if (srst) begin
      exp_q.delete(); past.delete();
      m_run = 1'b0; m_rate = 0; m_phase = 0;
    end else begin
      if (exp_vld && out_ready) void'(exp_q.pop_front());
      if (start) begin
        exp_q.delete(); past.delete();
        m_phase = 0;
        m_rate  = (rate == 2'd3) ? 0 : int'(rate);
        m_run   = 1'b1;
      end else if (in_valid && exp_rdy) begin
        model_accept(in_bit);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    srst = 1'b1; tick(); srst = 1'b0;
  endtask

  task automatic do_start(int r);
    start = 1'b1; rate = 2'(r); tick(); start = 1'b0;
  endtask

  task automatic feed(bit b);
    int  guard;
    bit  acc;
    guard = 0;
    in_valid = 1'b1;
    in_bit   = b;
    forever begin
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) break;
      guard++;
      if (guard > 200) begin
        check("feed_timeout", 1, 0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    in_valid   = 1'b0;
    while (exp_q.size() != 0 && g < 100) begin
      tick(); g++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    tick();
  endtask

  task automatic expect_got(string name, input bit v[$]);
    check({name, "_len"}, got.size(), v.size());
    for (int i = 0; i < v.size() && i < got.size(); i++)
      check(name, int'(got[i]), int'(v[i]));
  endtask

  initial begin
    bit v12[$];
    bit v34[$];
    bit v23[$];
    bit vflush[$];
    int lens[3];
    v12    = '{1,1,0,1,1,1,1,1,0,0,1,0,1,1};
    v34    = '{1,1,0,1,1,1,0,0};
    v23    = '{1,1,0,1,1,1};
    vflush = '{1,1,0,1};
    lens   = '{128, 96, 86};

    srst = 1'b1; start = 1'b0; rate = 2'd0;
    in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    srst = 1'b0;
    tick();
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;

    do_start(0); got.delete();
    feed(1); repeat (6) feed(0);
    drain();
    expect_got("impulse_r12", v12);

    do_start(2); got.delete(); acc_cycle.delete();
    feed(1); repeat (5) feed(0);
    drain();
    expect_got("impulse_r34", v34);
    check("acc_count_r34", acc_cycle.size(), 6);
    if (acc_cycle.size() >= 6) check("acc_span_r34", acc_cycle[5] - acc_cycle[0], 7);

    do_start(1); got.delete();
    feed(1); repeat (3) feed(0);
    drain();
    expect_got("impulse_r23", v23);

    for (int r = 0; r < 3; r++) begin
      do_start(r); got.delete();
      rand_ready = 1'b1;
      for (int i = 0; i < 64; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        feed(1'($urandom_range(0, 1)));
      end
      drain();
      check("random_len", got.size(), lens[r]);
    end

    do_start(0);
    out_ready = 1'b0;
    feed(1);
    tick();
    check("cnt2_valid", int'(out_valid), 1);
    do_start(2);
    @(negedge clk);
    check("start_flush", int'(out_valid), 0);
    tick();
    out_ready = 1'b1; got.delete();
    feed(1); feed(0); feed(0);
    drain();
    expect_got("restart_r34", vflush);

    do_start(1);
    out_ready = 1'b0;
    feed(1);
    do_reset();
    @(negedge clk);
    check("reset_valid", int'(out_valid), 0);
    tick();
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_in_ready", int'(in_ready), 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    do_start(3); got.delete();
    feed(1); repeat (6) feed(0);
    drain();
    expect_got("impulse_rsvd", v12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
